// File: rtl/smc_ahb_lite_mst8_pkg.sv
// Shared encodings for the SMC AHB-lite initiator: transfer types, sizes, responses,
// burst codes, FSM states and the local alignment check (used with SMC_MST_ALIGN_CHK_EN).
package smc_ahb_lite_mst8_pkg;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  localparam logic [1:0] RSP_OKAY  = 2'b00;
  localparam logic [1:0] RSP_ERROR = 2'b01;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR  = 3'd3
`ifdef SMC_MST_ALIGN_CHK_EN
    , ST_REJ = 3'd4
`endif
  } mst_state_e;

  function automatic logic misaligned(input logic [31:0] addr, input logic [2:0] size);
    return (size > SZ_WORD) ||
           ((size == SZ_HALF) && addr[0]) ||
           ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/smc_mst_wbuf8.sv
// One-entry write holding register. A load strobe moves the held word to hwdata and
// may refill in the same cycle, so back-to-back write beats need no BUSY.
module smc_mst_wbuf8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        active,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        ld,
  output logic        in_ready,
  output logic        full,
  output logic [31:0] hwdata
);
  logic        full_q, full_d;
  logic [31:0] data_q, data_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        fill;

  assign in_ready = active & (~full_q | ld);
  assign fill     = in_valid & in_ready;
  assign full     = full_q;
  assign hwdata   = hwdata_q;

  always_comb begin
    full_d   = full_q;
    data_d   = data_q;
    hwdata_d = hwdata_q;
    if (ld) begin
      hwdata_d = data_q;
      full_d   = 1'b0;
    end
    if (fill) begin
      data_d = in_data;
      full_d = 1'b1;
    end
    if (clr) full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= 1'b0;
      data_q   <= '0;
      hwdata_q <= '0;
    end else begin
      full_q   <= full_d;
      data_q   <= data_d;
      hwdata_q <= hwdata_d;
    end
  end
endmodule

// File: rtl/smc_ahb_lite_mst8.sv
// AHB-lite initiator for the SMC: single/INCR bursts with wait states, BUSY insertion
// and two-cycle ERROR abort. SMC_MST_ALIGN_CHK_EN enables local rejection of misaligned commands.
module smc_ahb_lite_mst8
  import smc_ahb_lite_mst8_pkg::*;
(
  input  logic        hclk8,
  input  logic        n_sys_reset8,
  input  logic        cmd_valid8,
  output logic        cmd_ready8,
  input  logic [31:0] cmd_addr8,
  input  logic        cmd_write8,
  input  logic [2:0]  cmd_size8,
  input  logic [3:0]  cmd_len8,
  input  logic        wd_valid8,
  output logic        wd_ready8,
  input  logic [31:0] wd_data8,
  output logic        rd_valid8,
  output logic [31:0] rd_data8,
  output logic        done8,
  output logic        err8,
  output logic [31:0] haddr8,
  output logic [1:0]  htrans8,
  output logic        hwrite8,
  output logic [2:0]  hsize8,
  output logic [2:0]  hburst8,
  output logic [31:0] hwdata8,
  input  logic        hready8,
  input  logic [1:0]  hresp8,
  input  logic [31:0] hrdata8
);
  mst_state_e  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [2:0]  hburst_q, hburst_d;
  logic [4:0]  beats_q, beats_d;      // address phases still to be accepted
  logic [4:0]  wd_left_q, wd_left_d;  // write words still to be taken in
  logic        nseq_q, nseq_d;        // pending beat must start a new NONSEQ
  logic        issued_q, issued_d;
  logic        dphase_q, dphase_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        rej, wd_active, wd_fire, wb_full, ld, addr_acc, bus_req;
  logic        data_ok, bus_err, buf_full_next;
  logic [31:0] addr_inc;

`ifdef SMC_MST_ALIGN_CHK_EN
  assign rej = misaligned(cmd_addr8, cmd_size8);
`else
  assign rej = 1'b0;
`endif

  assign cmd_ready8 = (state_q == ST_IDLE);
  assign bus_req    = htrans_q[1];
  assign addr_acc   = (state_q == ST_ADDR) & bus_req & hready8;
  assign ld         = addr_acc & hwrite_q;
  assign wd_fire    = wd_valid8 & wd_ready8;
  assign addr_inc   = 32'd1 << hsize_q;
  assign data_ok    = dphase_q & hready8 & (hresp8 == RSP_OKAY);
  assign bus_err    = dphase_q & ~hready8 & (hresp8 == RSP_ERROR);
  assign buf_full_next = (wb_full & ~ld) | wd_fire;

  always_comb begin
    wd_active = 1'b0;
    if (state_q == ST_IDLE)      wd_active = cmd_valid8 & cmd_write8 & ~rej;
    else if (state_q == ST_ADDR) wd_active = hwrite_q & (wd_left_q != 5'd0);
  end

  smc_mst_wbuf8 u_wbuf (
    .clk      (hclk8),
    .rst_n    (n_sys_reset8),
    .clr      (state_q == ST_ERR),
    .active   (wd_active),
    .in_valid (wd_valid8),
    .in_data  (wd_data8),
    .ld       (ld),
    .in_ready (wd_ready8),
    .full     (wb_full),
    .hwdata   (hwdata8)
  );

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    beats_d    = beats_q;
    wd_left_d  = wd_left_q - {4'd0, wd_fire};
    nseq_d     = nseq_q;
    issued_d   = issued_q;
    dphase_d   = dphase_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (data_ok && !hwrite_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = hrdata8;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid8) begin
`ifdef SMC_MST_ALIGN_CHK_EN
          if (rej) begin
            state_d = ST_REJ;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else
`endif
          begin
            state_d   = ST_ADDR;
            haddr_d   = cmd_addr8;
            hwrite_d  = cmd_write8;
            hsize_d   = cmd_size8;
            hburst_d  = (cmd_len8 != 4'd0) ? HBURST_INCR : HBURST_SINGLE;
            beats_d   = {1'b0, cmd_len8} + 5'd1;
            wd_left_d = beats_d - {4'd0, wd_fire};
            nseq_d    = 1'b1;
            issued_d  = 1'b0;
            htrans_d  = (!cmd_write8 || wd_fire) ? TRN_NONSEQ : TRN_IDLE;
          end
        end
      end
      ST_ADDR: begin
        if (hready8) dphase_d = 1'b0;
        if (bus_err) begin
          state_d  = ST_ERR;
          htrans_d = TRN_IDLE;
          dphase_d = 1'b0;
        end else if (!(bus_req && !hready8)) begin
          // A stalled NONSEQ/SEQ holds; IDLE/BUSY and accepted beats are re-decided
          if (addr_acc) begin
            beats_d  = beats_q - 5'd1;
            haddr_d  = haddr_q + addr_inc;
            nseq_d   = (haddr_d[10] != haddr_q[10]);
            issued_d = 1'b1;
            dphase_d = 1'b1;
          end
          if (beats_d == 5'd0) begin
            state_d  = ST_LAST;
            htrans_d = TRN_IDLE;
          end else if (!hwrite_q || buf_full_next) begin
            htrans_d = nseq_d ? TRN_NONSEQ : TRN_SEQ;
          end else begin
            htrans_d = issued_d ? TRN_BUSY : TRN_IDLE;
          end
        end
      end
      ST_LAST: begin
        if (bus_err) begin
          state_d  = ST_ERR;
          dphase_d = 1'b0;
        end else if (dphase_q && hready8) begin
          state_d  = ST_IDLE;
          dphase_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      ST_ERR: begin
        if (hready8) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
`ifdef SMC_MST_ALIGN_CHK_EN
      ST_REJ: state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk8 or negedge n_sys_reset8) begin
    if (!n_sys_reset8) begin
      state_q    <= ST_IDLE;
      haddr_q    <= '0;
      htrans_q   <= TRN_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= '0;
      hburst_q   <= '0;
      beats_q    <= '0;
      wd_left_q  <= '0;
      nseq_q     <= 1'b0;
      issued_q   <= 1'b0;
      dphase_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      beats_q    <= beats_d;
      wd_left_q  <= wd_left_d;
      nseq_q     <= nseq_d;
      issued_q   <= issued_d;
      dphase_q   <= dphase_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign haddr8    = haddr_q;
  assign htrans8   = htrans_q;
  assign hwrite8   = hwrite_q;
  assign hsize8    = hsize_q;
  assign hburst8   = hburst_q;
  assign rd_valid8 = rd_valid_q;
  assign rd_data8  = rd_data_q;
  assign done8     = done_q;
  assign err8      = err_q;
endmodule

// File: tb/tb_smc_ahb_lite_mst8.sv
module tb_smc_ahb_lite_mst8;
  logic        hclk8 = 1'b0;
  logic        n_sys_reset8 = 1'b1;
  logic        cmd_valid8 = 1'b0, cmd_write8 = 1'b0;
  logic [31:0] cmd_addr8 = '0;
  logic [2:0]  cmd_size8 = '0;
  logic [3:0]  cmd_len8 = '0;
  logic        wd_valid8 = 1'b0;
  logic [31:0] wd_data8 = '0;
  logic        hready8 = 1'b1;
  logic [1:0]  hresp8 = 2'b00;
  logic [31:0] hrdata8 = '0;
  logic        cmd_ready8, wd_ready8, rd_valid8, done8, err8, hwrite8;
  logic [31:0] rd_data8, haddr8, hwdata8;
  logic [1:0]  htrans8;
  logic [2:0]  hsize8, hburst8;

  int n_cmp = 0;
  int n_err = 0;
  bit finished = 1'b0;

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;

  smc_ahb_lite_mst8 dut (
    .hclk8(hclk8), .n_sys_reset8(n_sys_reset8),
    .cmd_valid8(cmd_valid8), .cmd_ready8(cmd_ready8), .cmd_addr8(cmd_addr8),
    .cmd_write8(cmd_write8), .cmd_size8(cmd_size8), .cmd_len8(cmd_len8),
    .wd_valid8(wd_valid8), .wd_ready8(wd_ready8), .wd_data8(wd_data8),
    .rd_valid8(rd_valid8), .rd_data8(rd_data8), .done8(done8), .err8(err8),
    .haddr8(haddr8), .htrans8(htrans8), .hwrite8(hwrite8), .hsize8(hsize8),
    .hburst8(hburst8), .hwdata8(hwdata8),
    .hready8(hready8), .hresp8(hresp8), .hrdata8(hrdata8)
  );

  always #5 hclk8 = ~hclk8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge hclk8);
  endtask

  task automatic cmd(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [3:0] l);
    cmd_valid8 = 1'b1; cmd_addr8 = a; cmd_write8 = w; cmd_size8 = s; cmd_len8 = l;
  endtask

  task automatic check_reset_vals(input string tg);
    chk({tg, "_cmd_ready"}, cmd_ready8, 1'b1);
    chk({tg, "_wd_ready"}, wd_ready8, 1'b0);
    chk({tg, "_rd_valid"}, rd_valid8, 1'b0);
    chk({tg, "_done"}, done8, 1'b0);
    chk({tg, "_err"}, err8, 1'b0);
    chk({tg, "_htrans"}, htrans8, IDL);
    chk({tg, "_haddr"}, haddr8, 32'h0);
    chk({tg, "_hwdata"}, hwdata8, 32'h0);
    chk({tg, "_rd_data"}, rd_data8, 32'h0);
    chk({tg, "_hwrite"}, hwrite8, 1'b0);
    chk({tg, "_hsize"}, hsize8, 3'd0);
    chk({tg, "_hburst"}, hburst8, 3'd0);
  endtask

  initial begin
    #20000;
    if (!finished) begin
      n_err++;
      $error("FAIL timeout: wait expired before the sequence completed");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #1 n_sys_reset8 = 1'b0;
    #2 check_reset_vals("rst");
    step(); step();
    n_sys_reset8 = 1'b1;

    step(); cmd(32'h100, 1'b0, 3'd2, 4'd0);
    chk("t1_cmd_ready", cmd_ready8, 1'b1);
    step(); cmd_valid8 = 1'b0;
    chk("t1_htrans", htrans8, NSQ); chk("t1_haddr", haddr8, 32'h100);
    chk("t1_hburst", hburst8, 3'b000); chk("t1_hsize", hsize8, 3'd2); chk("t1_hwrite", hwrite8, 1'b0);
    chk("t1_cmd_busy", cmd_ready8, 1'b0);
    step(); hrdata8 = 32'hDEADBEEF;
    chk("t1_htrans_dp", htrans8, IDL); chk("t1_rdv_early", rd_valid8, 1'b0);
    step(); hrdata8 = '0;
    chk("t1_rd_valid", rd_valid8, 1'b1); chk("t1_rd_data", rd_data8, 32'hDEADBEEF);
    chk("t1_done", done8, 1'b1); chk("t1_err", err8, 1'b0); chk("t1_cmd_ready2", cmd_ready8, 1'b1);

    step(); cmd(32'h3F8, 1'b1, 3'd2, 4'd3); wd_valid8 = 1'b1; wd_data8 = 32'hA0;
    #1 chk("t2_wd_ready", wd_ready8, 1'b1);
    step(); cmd_valid8 = 1'b0; wd_data8 = 32'hA1;
    chk("t2_tr0", htrans8, NSQ); chk("t2_ad0", haddr8, 32'h3F8); chk("t2_hburst", hburst8, 3'b001);
    chk("t2_hwrite", hwrite8, 1'b1);
    step(); wd_data8 = 32'hA2;
    chk("t2_tr1", htrans8, SQ); chk("t2_ad1", haddr8, 32'h3FC); chk("t2_wd0", hwdata8, 32'hA0);
    step(); wd_data8 = 32'hA3;
    chk("t2_tr2_1k", htrans8, NSQ); chk("t2_ad2", haddr8, 32'h400); chk("t2_wd1", hwdata8, 32'hA1);
    step(); wd_valid8 = 1'b0;
    chk("t2_tr3", htrans8, SQ); chk("t2_ad3", haddr8, 32'h404); chk("t2_wd2", hwdata8, 32'hA2);
    step();
    chk("t2_tr_end", htrans8, IDL); chk("t2_wd3", hwdata8, 32'hA3); chk("t2_done_early", done8, 1'b0);
    step();
    chk("t2_done", done8, 1'b1); chk("t2_err", err8, 1'b0);

    step(); cmd(32'h0, 1'b1, 3'd2, 4'd3); wd_valid8 = 1'b1; wd_data8 = 32'hB0;
    step(); cmd_valid8 = 1'b0; wd_data8 = 32'hB1;
    chk("t3_tr0", htrans8, NSQ); chk("t3_ad0", haddr8, 32'h0);
    step(); wd_valid8 = 1'b0;
    chk("t3_tr1", htrans8, SQ); chk("t3_ad1", haddr8, 32'h4);
    step();
    chk("t3_busy1", htrans8, BSY); chk("t3_busy1_ad", haddr8, 32'h8);
    step(); wd_valid8 = 1'b1; wd_data8 = 32'hB2;
    chk("t3_busy2", htrans8, BSY); chk("t3_busy2_ad", haddr8, 32'h8); chk("t3_busy_wd", hwdata8, 32'hB1);
    step(); wd_data8 = 32'hB3;
    chk("t3_tr2", htrans8, SQ); chk("t3_ad2", haddr8, 32'h8);
    step(); wd_valid8 = 1'b0;
    chk("t3_tr3", htrans8, SQ); chk("t3_ad3", haddr8, 32'hC); chk("t3_wd2", hwdata8, 32'hB2);
    step();
    chk("t3_wd3", hwdata8, 32'hB3);
    step();
    chk("t3_done", done8, 1'b1); chk("t3_err", err8, 1'b0);

    step(); cmd(32'h200, 1'b0, 3'd2, 4'd1);
    step(); cmd_valid8 = 1'b0; hready8 = 1'b0;
    chk("t4_tr_w1", htrans8, NSQ); chk("t4_ad_w1", haddr8, 32'h200);
    step();
    chk("t4_tr_w2", htrans8, NSQ); chk("t4_ad_w2", haddr8, 32'h200);
    step();
    chk("t4_tr_w3", htrans8, NSQ); chk("t4_hsize_w3", hsize8, 3'd2);
    step(); hready8 = 1'b1;
    chk("t4_tr_acc", htrans8, NSQ); chk("t4_ad_acc", haddr8, 32'h200);
    step(); hrdata8 = 32'h1111;
    chk("t4_tr1", htrans8, SQ); chk("t4_ad1", haddr8, 32'h204);
    step(); hrdata8 = 32'h2222;
    chk("t4_rv0", rd_valid8, 1'b1); chk("t4_rd0", rd_data8, 32'h1111); chk("t4_tr_end", htrans8, IDL);
    step(); hrdata8 = '0;
    chk("t4_rv1", rd_valid8, 1'b1); chk("t4_rd1", rd_data8, 32'h2222); chk("t4_done", done8, 1'b1);
    chk("t4_err", err8, 1'b0);

    step(); cmd(32'h300, 1'b0, 3'd2, 4'd7);
    step(); cmd_valid8 = 1'b0;
    chk("t5_tr0", htrans8, NSQ);
    step(); hrdata8 = 32'h5A5A;
    chk("t5_tr1", htrans8, SQ); chk("t5_ad1", haddr8, 32'h304);
    step(); hrdata8 = '0; hresp8 = 2'b01; hready8 = 1'b0;
    chk("t5_tr2", htrans8, SQ); chk("t5_rv0", rd_valid8, 1'b1); chk("t5_rd0", rd_data8, 32'h5A5A);
    step(); hready8 = 1'b1;
    chk("t5_tr_cancel", htrans8, IDL); chk("t5_rv_err", rd_valid8, 1'b0); chk("t5_done_early", done8, 1'b0);
    step(); hresp8 = 2'b00;
    chk("t5_done", done8, 1'b1); chk("t5_err", err8, 1'b1); chk("t5_rv_none", rd_valid8, 1'b0);
    step();
    chk("t5_cmd_ready", cmd_ready8, 1'b1); chk("t5_tr_idle", htrans8, IDL); chk("t5_done_pulse", done8, 1'b0);

    step(); cmd(32'h102, 1'b0, 3'd2, 4'd0);
    step(); cmd_valid8 = 1'b0;
`ifdef SMC_MST_ALIGN_CHK_EN
    chk("t6_tr_rej", htrans8, IDL); chk("t6_done", done8, 1'b1); chk("t6_err", err8, 1'b1);
    step();
    chk("t6_tr_rej2", htrans8, IDL); chk("t6_cmd_ready", cmd_ready8, 1'b1); chk("t6_done_pulse", done8, 1'b0);
`else
    chk("t6_tr", htrans8, NSQ); chk("t6_ad", haddr8, 32'h102);
    step(); hrdata8 = 32'h77;
    step(); hrdata8 = '0;
    chk("t6_done", done8, 1'b1); chk("t6_err", err8, 1'b0); chk("t6_rd", rd_data8, 32'h77);
`endif

    step(); cmd(32'h600, 1'b1, 3'd2, 4'd3); wd_valid8 = 1'b1; wd_data8 = 32'hC0;
    step(); cmd_valid8 = 1'b0; wd_data8 = 32'hC1;
    step(); wd_data8 = 32'hC2;
    step(); wd_data8 = 32'hC3;
    chk("t7_tr_pre", htrans8, SQ); chk("t7_wd_pre", hwdata8, 32'hC1);
    n_sys_reset8 = 1'b0; wd_valid8 = 1'b0;
    #1 check_reset_vals("t7");
    step(); step();
    n_sys_reset8 = 1'b1;
    step(); cmd(32'h700, 1'b1, 3'd2, 4'd0); wd_valid8 = 1'b1; wd_data8 = 32'hE0;
    #1 chk("t7_wd_ready", wd_ready8, 1'b1);
    step(); cmd_valid8 = 1'b0; wd_valid8 = 1'b0;
    chk("t7_tr", htrans8, NSQ); chk("t7_ad", haddr8, 32'h700); chk("t7_hburst", hburst8, 3'b000);
    step();
    chk("t7_wd", hwdata8, 32'hE0);
    step();
    chk("t7_done", done8, 1'b1); chk("t7_err", err8, 1'b0);

    finished = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
